// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Access-cycle counter: cleared outside ACCESS, expires on the last allowed cycle.
module arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between fetch (I) and load/store (D)
// requesters with alignment checking, access timeout and fetch anti-starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              owner_d
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t state, next_state;

    logic [SW-1:0]     starve_cnt;
    logic              starve_hit, grant_d, grant_i, win_bad;
    logic [ADDR_W-1:0] win_addr;
    logic              tmo_expire;

    logic              mem_req_nxt, mem_we_nxt, owner_nxt, busy_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic              i_done_nxt, i_err_nxt, d_done_nxt, d_err_nxt;

    arb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ACCESS),
        .enable (state == ACCESS),
        .expire (tmo_expire)
    );

    // D normally wins; a waiting fetch is forced once D has had STARVE_LIMIT grants in a row.
    always_comb begin
        starve_hit = i_req && (starve_cnt == STARVE_MAX);
        grant_d    = d_req && !starve_hit;
        grant_i    = i_req && !grant_d;
        win_addr   = grant_d ? d_addr : i_addr;
        win_bad    = is_misaligned(win_addr[1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_d || grant_i) next_state = win_bad ? RESP : ACCESS;
            ACCESS:  if (mem_ack || tmo_expire) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        owner_nxt     = owner_d;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        i_done_nxt    = 1'b0;
        i_err_nxt     = 1'b0;
        d_done_nxt    = 1'b0;
        d_err_nxt     = 1'b0;
        busy_nxt      = (next_state != IDLE);
        case (state)
            IDLE: begin
                if (grant_d || grant_i) begin
                    owner_nxt     = grant_d ? OWN_D : OWN_I;
                    mem_addr_nxt  = win_addr;
                    mem_we_nxt    = grant_d && d_we && !win_bad;
                    mem_wdata_nxt = grant_d ? d_wdata : '0;
                    mem_req_nxt   = !win_bad;
                    if (win_bad) begin
                        if (grant_d) begin
                            d_err_nxt   = 1'b1;
                            d_rdata_nxt = '0;
                        end else begin
                            i_err_nxt   = 1'b1;
                            i_rdata_nxt = '0;
                        end
                    end
                end
            end
            ACCESS: begin
                // Ack takes precedence over a timeout landing in the same cycle.
                if (mem_ack || tmo_expire) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    if (owner_d == OWN_D) begin
                        d_done_nxt  = mem_ack;
                        d_err_nxt   = !mem_ack;
                        d_rdata_nxt = mem_ack ? mem_rdata : '0;
                    end else begin
                        i_done_nxt  = mem_ack;
                        i_err_nxt   = !mem_ack;
                        i_rdata_nxt = mem_ack ? mem_rdata : '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner_d   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            owner_d   <= owner_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            i_done    <= i_done_nxt;
            i_err     <= i_err_nxt;
            d_done    <= d_done_nxt;
            d_err     <= d_err_nxt;
            busy      <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d && i_req) begin
                if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_d || grant_i) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the multicycle core's instruction-fetch requester (I) and its load/store requester (D).
- Sits between the core controller/datapath and the unified memory model.
- Serialises accesses, checks alignment, bounds memory latency with a timeout, and prevents fetch starvation.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TIMEOUT_CYCLES, 16: ACCESS-state cycles without mem_ack before the access is aborted with an error. Minimum 1.
- STARVE_LIMIT, 4: consecutive D grants allowed while i_req is pending before I is forced. Minimum 1.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- i_req, in, 1: fetch request, level.
- i_addr, in, ADDR_W: fetch address.
- i_rdata, out, DATA_W: fetched word. Valid while i_done=1.
- i_done, out, 1: one-cycle completion pulse.
- i_err, out, 1: one-cycle error pulse. Fires on misalignment or timeout.
- d_req, in, 1: data request, level.
- d_we, in, 1: 1 = store, 0 = load.
- d_addr, in, ADDR_W: data address.
- d_wdata, in, DATA_W: store data.
- d_rdata, out, DATA_W: load data. Valid while d_done=1.
- d_done, out, 1: one-cycle completion pulse.
- d_err, out, 1: one-cycle error pulse.
- mem_req, out, 1: memory request. Held until ack or timeout.
- mem_we, out, 1: memory write enable.
- mem_addr, out, ADDR_W: memory address.
- mem_wdata, out, DATA_W: memory write data.
- mem_rdata, in, DATA_W: memory read data. Valid with mem_ack.
- mem_ack, in, 1: memory completion, one cycle.
- busy, out, 1: high in ACCESS and RESP.
- owner_d, out, 1: 1 = D owns the current/last transaction.

Behaviour:
Reset
- rst=0 asynchronously forces state to IDLE.
- All outputs go to 0, timeout counter to 0, starvation counter to 0.
- Reset mid-ACCESS drops mem_req immediately. No done/err is produced for that access.

State machine: IDLE, ACCESS, RESP. All outputs are registered.

IDLE
- Arbitration happens only in IDLE, sampled at the rising edge.
- Priority: D wins if d_req=1, unless i_req=1 and starve_cnt==STARVE_LIMIT, in which case I wins.
- Winner's addr/we/wdata are latched and owner_d is set. I is always a read (mem_we=0).
- Requester inputs are don't-care after grant.
- Misaligned winner (addr[1:0]!=0): state goes to RESP with err flag set; mem_req is never asserted.
- Otherwise: state goes to ACCESS; mem_req=1, mem_addr, mem_we and mem_wdata are driven from the next cycle.
- Neither request high: remain in IDLE.

Starvation counter
- D granted while i_req=1: increment, saturating at STARVE_LIMIT.
- I granted, or D granted with i_req=0: clear to 0.

ACCESS
- mem_* outputs held stable; tmo_cnt increments each cycle.
- mem_ack=1: capture mem_rdata, deassert mem_req, go to RESP with err=0.
- tmo_cnt==TIMEOUT_CYCLES-1 without ack: deassert mem_req, go to RESP with err=1, rdata=0.
- Ack and timeout in the same cycle: ack wins.

RESP (exactly one cycle)
- Owner's done pulses, or err pulses if the error flag is set. done and err are never both high.
- Owner's rdata is valid; on a store, rdata carries mem_rdata as captured (don't-care).
- The non-owner's done/err stay 0.
- Next state is IDLE.

Other rules
- mem_ack outside ACCESS is ignored (late acks after timeout are dropped).
- A requester that wants no further access must deassert req at the edge ending its done/err cycle; a req still high in IDLE is a new request.
- Minimum latency, req to done: 3 cycles with a zero-wait memory (ack in the first ACCESS cycle).
- Misaligned access: error after 2 cycles.

Decomposition:
- Package mem_arb_pkg holds the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), the owner constants (OWN_I=0, OWN_D=1) and the helper function is_misaligned(addr).
- One sub-module, arb_timeout_ctr: clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES)+1, instantiated once.
- Arbitration, starvation counter and datapath latches stay in the top module.

Test Plan:
- Reset: hold rst=0 mid-ACCESS with mem_req=1 -> all outputs 0 asynchronously; after release, state is IDLE, no done/err.
- Single fetch: i_req=1, i_addr=0x00400000, memory acks 2 cycles after mem_req with 0x00500093 -> mem_we=0, i_rdata=0x00500093, i_done pulses once, 4 cycles after grant edge.
- Collision: i_req=d_req=1 continuously, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF, STARVE_LIMIT=4 -> 4 D stores (mem_we=1, mem_wdata=0xDEADBEEF), then 1 I read, then D resumes; starve counter reset observed.
- Misaligned: d_req=1, d_addr=0x10010002 -> mem_req never rises; d_err pulses 2 cycles after request; d_done stays 0.
- Timeout: i_req=1, memory never acks, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then i_err pulse with i_rdata=0; an ack injected 3 cycles later is ignored.
- Ack on final timeout cycle: mem_ack=1 in the 16th ACCESS cycle with 0x12345678 -> i_done=1, i_err=0, i_rdata=0x12345678.
